// File: rtl/seq_cpu_core.sv
// Multi-cycle accumulator CPU core with an AR/PC/IR/DR/AC/E register model.
// It has a variable-latency memory handshake, indirect addressing, an interrupt cycle and HLT.
module seq_cpu_core #(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    input  logic          irq,
    output logic [DW-1:0] ac_data,
    output logic [AW-1:0] pc_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          halted
);
    typedef enum logic [2:0] {FETCH, DECODE, INDIR, OPRD, OPWR, REGIO, INTR, HALT} state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    state_t        state, state_next;
    logic [AW-1:0] ar, pc;
    logic [DW-1:0] ir, dr, ac;
    logic          e, ien;

    logic [2:0]    opcode;
    logic          ind;
    logic          mem_done;
    logic [DW:0]   sum;
    logic [DW-1:0] pc_ext;

    logic          acc, acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;

    logic [DW-1:0] r_ac;
    logic          r_e, r_skip;
    logic [DW:0]   rot;

    assign opcode   = ir[AW+2:AW];
    assign ind      = ir[AW+3];
    assign mem_done = mem_req & mem_ack;
    assign sum      = {1'b0, ac} + {1'b0, mem_rdata};
    assign pc_ext   = {{(DW-AW){1'b0}}, pc};

    assign ac_data  = ac;
    assign pc_data  = pc;
    assign halted   = (state == HALT);

    // Execute phase reached once the effective address is known.
    function automatic state_t exec_state(input logic [2:0] op);
        case (op)
            OP_BUN:          return FETCH;
            OP_STA, OP_BSA:  return OPWR;
            default:         return OPRD;
        endcase
    endfunction

    // Register-reference bits applied in priority order, each on the previous result.
    always_comb begin
        r_ac   = ac;
        r_e    = e;
        rot    = '0;
        r_skip = 1'b0;
        if (ir[11]) r_ac = '0;
        if (ir[10]) r_e = 1'b0;
        if (ir[9])  r_ac = ~r_ac;
        if (ir[8])  r_e = ~r_e;
        if (ir[7]) begin
            rot        = {r_e, r_ac};
            {r_e, r_ac} = {rot[0], rot[DW:1]};
        end
        if (ir[6]) begin
            rot        = {r_e, r_ac};
            {r_e, r_ac} = {rot[DW-1:0], rot[DW]};
        end
        if (ir[5])  r_ac = r_ac + DW'(1);
        r_skip = (ir[4] & ~r_ac[DW-1]) | (ir[3] & r_ac[DW-1]) |
                 (ir[2] & (r_ac == '0)) | (ir[1] & ~r_e);
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        acc        = 1'b0;
        acc_we     = 1'b0;
        acc_addr   = ar;
        acc_wdata  = ac;
        case (state)
            FETCH: begin
                acc_addr = pc;
                if (mem_req) begin
                    if (mem_ack) state_next = DECODE;
                end else if (en) begin
                    if (ien && irq) state_next = INTR;
                    else            acc = 1'b1;
                end
            end
            DECODE: begin
                if (opcode == OP_REG) state_next = REGIO;
                else if (ind)         state_next = INDIR;
                else                  state_next = exec_state(opcode);
            end
            INDIR: begin
                acc = 1'b1;
                if (mem_done) state_next = exec_state(opcode);
            end
            OPRD: begin
                acc = 1'b1;
                if (mem_done) state_next = (opcode == OP_ISZ) ? OPWR : FETCH;
            end
            OPWR: begin
                acc    = 1'b1;
                acc_we = 1'b1;
                case (opcode)
                    OP_STA:  acc_wdata = ac;
                    OP_BSA:  acc_wdata = pc_ext;
                    default: acc_wdata = dr;
                endcase
                if (mem_done) state_next = FETCH;
            end
            REGIO: state_next = (!ind && ir[0]) ? HALT : FETCH;
            INTR: begin
                acc       = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = '0;
                acc_wdata = pc_ext;
                if (mem_done) state_next = FETCH;
            end
            default: state_next = HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar        <= '0;
            pc        <= '0;
            ir        <= '0;
            dr        <= '0;
            ac        <= '0;
            e         <= 1'b0;
            ien       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // Request attributes are captured once and held until the ack edge.
            if (mem_done) begin
                mem_req <= 1'b0;
            end else if (acc && !mem_req) begin
                mem_req   <= 1'b1;
                mem_we    <= acc_we;
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
            end

            case (state)
                FETCH: if (mem_done) begin
                    ir <= mem_rdata;
                    pc <= pc + AW'(1);
                end
                DECODE: if (opcode != OP_REG) begin
                    ar <= ir[AW-1:0];
                    if (!ind && opcode == OP_BUN) pc <= ir[AW-1:0];
                end
                INDIR: if (mem_done) begin
                    ar <= mem_rdata[AW-1:0];
                    if (opcode == OP_BUN) pc <= mem_rdata[AW-1:0];
                end
                OPRD: if (mem_done) begin
                    dr <= mem_rdata;
                    case (opcode)
                        OP_AND:  ac <= ac & mem_rdata;
                        OP_ADD:  {e, ac} <= sum;
                        OP_LDA:  ac <= mem_rdata;
                        OP_ISZ:  dr <= mem_rdata + DW'(1);
                        default: ;
                    endcase
                end
                OPWR: if (mem_done) begin
                    if (opcode == OP_BSA) pc <= ar + AW'(1);
                    if (opcode == OP_ISZ && dr == '0) pc <= pc + AW'(1);
                end
                REGIO: begin
                    if (!ind) begin
                        ac <= r_ac;
                        e  <= r_e;
                        if (r_skip) pc <= pc + AW'(1);
                    end else begin
                        if (ir[10]) begin
                            out_data  <= ac[7:0];
                            out_valid <= 1'b1;
                        end
                        if (ir[6])      ien <= 1'b0;
                        else if (ir[7]) ien <= 1'b1;
                    end
                end
                INTR: if (mem_done) begin
                    pc  <= AW'(1);
                    ien <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_cpu_core.sv
// Directed bench for seq_cpu_core: a behavioural memory with programmable ack latency
// runs small hand-assembled programs and compares against hand-computed results.
module tb_seq_cpu_core;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset, en, irq;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, pc_data;
    logic [DW-1:0] mem_wdata, mem_rdata, ac_data;
    logic [7:0]    out_data;
    logic          out_valid, halted;

    always #5 clk = ~clk;

    seq_cpu_core #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .irq       (irq),
        .ac_data   (ac_data),
        .pc_data   (pc_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_pass   = 0;

    int  fixed_delay = 1;
    bit  rand_mode   = 0;
    bit  in_txn      = 0;
    int  wait_cnt    = 0;
    int  cur_delay   = 0;
    logic [AW-1:0] txn_addr;
    logic          txn_we;
    logic [DW-1:0] txn_wdata;

    int stab_err        = 0;
    int txn_count       = 0;
    int first_write_txn = -1;
    int out_pulses      = 0;
    logic [AW-1:0] last_waddr = '0;
    logic [DW-1:0] last_wdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory responder: drives ack/rdata away from the active edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
    end

    always @(negedge clk) begin
        if (out_valid) out_pulses++;
        if (mem_req) begin
            if (!in_txn) begin
                in_txn    = 1;
                wait_cnt  = 0;
                cur_delay = rand_mode ? int'($urandom_range(0, 7)) : fixed_delay;
                txn_addr  = mem_addr;
                txn_we    = mem_we;
                txn_wdata = mem_wdata;
            end else if (mem_addr !== txn_addr || mem_we !== txn_we ||
                         (mem_we && mem_wdata !== txn_wdata)) begin
                stab_err++;
            end
            if (wait_cnt >= cur_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            in_txn  = 0;
            mem_ack = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!reset && mem_req && mem_ack) begin
            txn_count++;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                last_waddr    = mem_addr;
                last_wdata    = mem_wdata;
                if (first_write_txn < 0) first_write_txn = txn_count - 1;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        irq   = 1'b0;
        repeat (2) @(negedge clk);
        reset           = 1'b0;
        txn_count       = 0;
        first_write_txn = -1;
        out_pulses      = 0;
        stab_err        = 0;
    endtask

    task automatic wait_halt(input int max_cyc, input string tag);
        int cyc = 0;
        while (!halted && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic wait_pc(input logic [AW-1:0] target, input int max_cyc, input string tag);
        int cyc = 0;
        while (pc_data !== target && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_reach_pc"}, 32'(pc_data), 32'(target));
    endtask

    task automatic load_prog1();
        clear_mem();
        mem[0]     = 16'h2010;  // LDA 0x010
        mem[1]     = 16'h1011;  // ADD 0x011
        mem[2]     = 16'h7001;  // HLT
        mem[12'h010] = 16'hFFFF;
        mem[12'h011] = 16'h0002;
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        irq   = 1'b0;

        // 1: LDA/ADD/HLT with one wait cycle per access.
        load_prog1();
        fixed_delay = 1;
        rand_mode   = 0;
        do_reset();
        check("rst_pc", 32'(pc_data), 32'd0);
        check("rst_ac", 32'(ac_data), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        en = 1'b1;
        wait_halt(500, "t1");
        check("t1_ac", 32'(ac_data), 32'h0001);
        check("t1_e", 32'(dut.e), 32'd1);
        check("t1_pc", 32'(pc_data), 32'd3);

        // 2: indirect load, then store.
        clear_mem();
        mem[0]       = 16'hA020;  // I LDA 0x020
        mem[1]       = 16'h3040;  // STA 0x040
        mem[2]       = 16'h7001;  // HLT
        mem[12'h020] = 16'h0030;
        mem[12'h030] = 16'h1234;
        do_reset();
        en = 1'b1;
        wait_halt(500, "t2");
        check("t2_ac", 32'(ac_data), 32'h1234);
        check("t2_store", 32'(mem[12'h040]), 32'h1234);
        check("t2_store_addr", 32'(last_waddr), 32'h040);
        check("t2_txn_before_write", 32'(first_write_txn), 32'd4);
        check("t2_txn_total", 32'(txn_count), 32'd6);
        check("t2_pc", 32'(pc_data), 32'd3);

        // 3: ISZ without skip, BSA, then ISZ wrapping to zero and skipping.
        clear_mem();
        mem[0]       = 16'h6051;  // ISZ 0x051
        mem[1]       = 16'h5060;  // BSA 0x060
        mem[12'h061] = 16'h4005;  // BUN 0x005
        mem[2]       = 16'h7001;  // HLT (reached only on a wrong skip)
        mem[5]       = 16'h6050;  // ISZ 0x050
        mem[6]       = 16'h7001;  // HLT (skipped)
        mem[7]       = 16'h7001;  // HLT
        mem[12'h050] = 16'hFFFF;
        mem[12'h051] = 16'h0005;
        do_reset();
        en = 1'b1;
        wait_halt(500, "t3");
        check("t3_isz_nowrap", 32'(mem[12'h051]), 32'h0006);
        check("t3_bsa_ret", 32'(mem[12'h060]), 32'h0002);
        check("t3_isz_wrap", 32'(mem[12'h050]), 32'h0000);
        check("t3_pc", 32'(pc_data), 32'd8);

        // 4: interrupt requested during ADD is taken at the next boundary.
        clear_mem();
        mem[0]       = 16'h4010;  // BUN 0x010
        mem[1]       = 16'h7001;  // ISR: HLT
        mem[12'h010] = 16'hF080;  // ION
        mem[12'h011] = 16'h1020;  // ADD 0x020
        mem[12'h012] = 16'h7001;  // HLT (not reached)
        mem[12'h020] = 16'h0003;
        do_reset();
        en = 1'b1;
        wait_pc(12'h012, 500, "t4");
        irq = 1'b1;
        wait_halt(500, "t4");
        irq = 1'b0;
        check("t4_ac", 32'(ac_data), 32'h0003);
        check("t4_ret_pc", 32'(mem[0]), 32'h0012);
        check("t4_waddr", 32'(last_waddr), 32'h000);
        check("t4_pc", 32'(pc_data), 32'd2);
        check("t4_ien", 32'(dut.ien), 32'd0);

        // 5: random ack latency, en dropped mid-instruction.
        load_prog1();
        rand_mode = 1;
        do_reset();
        en = 1'b1;
        wait_pc(12'h001, 500, "t5");
        en = 1'b0;
        repeat (100) @(negedge clk);
        check("t5_stop_ac", 32'(ac_data), 32'hFFFF);
        check("t5_stop_pc", 32'(pc_data), 32'd1);
        check("t5_stop_req", 32'(mem_req), 32'd0);
        check("t5_stop_txn", 32'(txn_count), 32'd2);
        check("t5_stop_halted", 32'(halted), 32'd0);
        en = 1'b1;
        wait_halt(1000, "t5");
        check("t5_ac", 32'(ac_data), 32'h0001);
        check("t5_e", 32'(dut.e), 32'd1);
        check("t5_pc", 32'(pc_data), 32'd3);
        check("t5_addr_stable", 32'(stab_err), 32'd0);
        rand_mode = 0;

        // 6: reset during an outstanding request, then OUT.
        clear_mem();
        mem[0]       = 16'h2010;  // LDA 0x010
        mem[1]       = 16'hF400;  // OUT
        mem[2]       = 16'h7001;  // HLT
        mem[12'h010] = 16'h00A5;
        fixed_delay  = 5;
        do_reset();
        en = 1'b1;
        begin
            int cyc = 0;
            while (!(pc_data == 12'h001 && mem_req) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("t6_req_seen", 32'(mem_req), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        check("t6_req_dropped", 32'(mem_req), 32'd0);
        check("t6_pc_cleared", 32'(pc_data), 32'd0);
        reset      = 1'b0;
        out_pulses = 0;
        wait_halt(500, "t6");
        repeat (2) @(negedge clk);
        check("t6_out_data", 32'(out_data), 32'h00A5);
        check("t6_out_pulses", 32'(out_pulses), 32'd1);
        check("t6_pc", 32'(pc_data), 32'd3);
        fixed_delay = 0;

        // 7: AND and register-reference chains (rotate through E, single skip).
        clear_mem();
        mem[0]       = 16'h2010;  // LDA 0x010
        mem[1]       = 16'h0011;  // AND 0x011
        mem[2]       = 16'h7040;  // CIL
        mem[3]       = 16'h7080;  // CIR
        mem[4]       = 16'h700A;  // SNA|SZE: both true, one skip
        mem[5]       = 16'h7001;  // HLT (skipped)
        mem[6]       = 16'h7220;  // CMA|INC
        mem[7]       = 16'h7101;  // CME|HLT
        mem[12'h010] = 16'hC0F1;
        mem[12'h011] = 16'h8003;
        do_reset();
        en = 1'b1;
        wait_halt(500, "t7");
        check("t7_ac", 32'(ac_data), 32'h7FFF);
        check("t7_e", 32'(dut.e), 32'd1);
        check("t7_pc", 32'(pc_data), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
